spi_slave: RTL
==============

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth on sclk, mosi, cs_n (min 2).
REQ-002 Parameter MIN_HALF, default 4: minimum raw_clk cycles per sclk high/low phase the block SHALL tolerate.
REQ-003 raw_clk  input  1  sole clock; every flop on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 width_16  input  1  word length select (0 = 8 bit, 1 = 16 bit); sampled at cs_n falling.
REQ-006 data_tx  input  16  next word to transmit (8-bit mode uses [7:0]).
REQ-007 load_tx  input  1  one-cycle strobe; latches data_tx into tx holding register.
REQ-008 data_rx  output  16  last complete received word, zero-extended in 8-bit mode.
REQ-009 rx_valid  output  1  one-cycle pulse when data_rx updates.
REQ-010 rx_full  output  1  set with rx_valid, cleared by rx_ack.
REQ-011 rx_ack  input  1  one-cycle strobe clearing rx_full.
REQ-012 overrun  output  1  sticky; set when a word completes while rx_full=1; cleared by rx_ack.
REQ-013 busy  output  1  high while state is not IDLE.
REQ-014 sclk, mosi, cs_n  input  1 each  external SPI pins, asynchronous to raw_clk.
REQ-015 miso  output  1  serial out; 0 while cs_n synchronized high.

Function
REQ-016 SPI mode 0 (CPOL=0, CPHA=0), MSB first.
REQ-017 sclk/mosi/cs_n SHALL pass SYNC_STAGES flops; edges detected on synchronized values only.
REQ-018 States: IDLE, SHIFT, WORD_DONE.
REQ-019 IDLE -> SHIFT on synchronized cs_n falling: latch width_16, bit count = 0, load tx shift register from holding register, drive MSB on miso the same cycle.
REQ-020 SHIFT, sclk rising: shift synchronized mosi into rx shift register LSB, bit count +1.
REQ-021 SHIFT, sclk falling: shift tx register left, miso = new MSB (bit 7 or 15 per width).
REQ-022 Bit count reaching 8 (or 16) -> WORD_DONE for exactly one cycle: data_rx <= rx shift register, rx_valid = 1, rx_full = 1, overrun set if rx_full already 1.
REQ-023 WORD_DONE -> SHIFT if cs_n still low: bit count = 0, tx reloaded from holding register, next-word MSB on miso before next sclk rising; else -> IDLE.
REQ-024 cs_n rising in SHIFT with partial word: discard partial bits, no rx_valid, data_rx unchanged, -> IDLE next cycle.
REQ-025 rx_ack and word completion in the same cycle: rx_full stays 1, overrun NOT set.
REQ-026 load_tx during SHIFT updates only the holding register; the word in flight is unaffected.
REQ-027 Holding register not reloaded between words: same value retransmitted.
REQ-028 width_16 changes during SHIFT SHALL have no effect until next cs_n falling.
REQ-029 Latency: rx_valid asserts SYNC_STAGES+2 raw_clk cycles after the final sclk rising edge at the pin.
REQ-030 Correct operation guaranteed for sclk phases >= MIN_HALF raw_clk cycles; shorter phases unspecified but SHALL not lock the FSM (cs_n high always returns to IDLE).

Reset
REQ-031 reset SHALL force: state IDLE, data_rx 0, rx_valid 0, rx_full 0, overrun 0, busy 0, miso 0, holding register 0, shift registers 0, bit count 0, synchronizer flops to idle levels (sclk 0, mosi 0, cs_n 1).
REQ-032 reset mid-word SHALL abort the transfer; after release, a new transfer starts only on a fresh cs_n falling edge.

Structure
REQ-033 Shared package/include holds state encodings, SPI mode constant, and word widths (8, 16) used also by the existing spi master.
REQ-034 One sub-module, spi_sync: parameterized SYNC_STAGES synchronizer plus rise/fall pulse outputs, instantiated for sclk and cs_n; mosi uses its level output.
REQ-035 Peripheral-bus mapping (register decode) SHALL live in the peripherals block, not here.

Verification
REQ-036 8-bit: load_tx 0x00A5, master sends 0x3C at raw_clk/8 -> miso shifts 0xA5, data_rx 0x003C, one rx_valid pulse, rx_full 1, overrun 0.
REQ-037 16-bit: width_16=1, tx 0xBEEF, master sends 0x1234 -> miso 0xBEEF, data_rx 0x1234, single rx_valid.
REQ-038 Back-to-back: cs_n held low, two 8-bit words 0x11, 0x22, no rx_ack -> two rx_valid, data_rx 0x0022, overrun 1; rx_ack clears rx_full and overrun.
REQ-039 Abort: cs_n raised after 5 bits -> no rx_valid, data_rx unchanged, busy 0 within SYNC_STAGES+2 cycles; next full word received correctly.
REQ-040 reset asserted mid-16-bit word -> all outputs at reset values next cycle; following transfer of 0x00FF received correctly.
REQ-041 rx_ack coincident with second word completion -> rx_full 1, overrun 0.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// Shared SPI definitions: FSM encodings, bus mode and word widths.
// The spi master uses the same width constants.
package spi_slave_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_SHIFT     = 2'd1;
  localparam logic [1:0] ST_WORD_DONE = 2'd2;

  // Mode 0: CPOL=0, CPHA=0
  localparam int unsigned SPI_MODE = 0;

  localparam int unsigned WORD_W8  = 8;
  localparam int unsigned WORD_W16 = 16;

  function automatic logic [4:0] word_bits(input logic wide);
    return wide ? 5'(WORD_W16) : 5'(WORD_W8);
  endfunction

endpackage

// File: rtl/spi_slave_if.sv
// Parallel-side handshake between the SPI slave and its host logic.
interface spi_slave_if;
  logic        width_16;
  logic [15:0] data_tx;
  logic        load_tx;
  logic [15:0] data_rx;
  logic        rx_valid;
  logic        rx_full;
  logic        rx_ack;
  logic        overrun;
  logic        busy;

  modport slave (
    input  width_16, data_tx, load_tx, rx_ack,
    output data_rx, rx_valid, rx_full, overrun, busy
  );

  modport master (
    output width_16, data_tx, load_tx, rx_ack,
    input  data_rx, rx_valid, rx_full, overrun, busy
  );
endinterface

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous pin, with edge pulses
// derived from the synchronized level only.
module spi_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] stage_q;
  logic                   prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stage_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q  <= RESET_VAL;
    end else begin
      stage_q <= {stage_q[SYNC_STAGES-2:0], d_i};
      prev_q  <= stage_q[SYNC_STAGES-1];
    end
  end

  assign level_o = stage_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~prev_q;
  assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/spi_slave.sv
// Mode-0 SPI slave, MSB first, 8/16-bit words, oversampled by raw_clk.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MIN_HALF    = 4
) (
  input  logic       raw_clk,
  input  logic       reset,
  spi_slave_if.slave bus,
  input  logic       sclk_i,
  input  logic       mosi_i,
  input  logic       cs_n_i,
  output logic       miso_o
);

  logic sclk_rise, sclk_fall, cs_lvl, cs_fall, mosi_lvl;
  logic unused_sclk_lvl, unused_cs_rise, unused_mosi_rise, unused_mosi_fall;
  // Short sclk phases need no extra logic: cs_n high always forces IDLE.
  logic unused_cfg;
  assign unused_cfg = ^{MIN_HALF, SPI_MODE};

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk_i(raw_clk), .rst_i(reset), .d_i(sclk_i),
    .level_o(unused_sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );
  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk_i(raw_clk), .rst_i(reset), .d_i(cs_n_i),
    .level_o(cs_lvl), .rise_o(unused_cs_rise), .fall_o(cs_fall)
  );
  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk_i(raw_clk), .rst_i(reset), .d_i(mosi_i),
    .level_o(mosi_lvl), .rise_o(unused_mosi_rise), .fall_o(unused_mosi_fall)
  );

  logic [1:0]  state_q, state_d;
  logic        width_q, width_d;
  logic [4:0]  cnt_q, cnt_d, cnt_inc;
  logic [15:0] tx_q, tx_d, rx_q, rx_d, hold_q, hold_d, data_rx_q, data_rx_d;
  logic        rx_valid_q, rx_valid_d, rx_full_q, rx_full_d, overrun_q, overrun_d;
  logic        word_done;

  assign cnt_inc   = cnt_q + 5'd1;
  assign word_done = (state_q == ST_WORD_DONE);

  always_comb begin
    state_d    = state_q;
    width_d    = width_q;
    cnt_d      = cnt_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    data_rx_d  = data_rx_q;
    rx_valid_d = 1'b0;
    hold_d     = bus.load_tx ? bus.data_tx : hold_q;
    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d = ST_SHIFT;
          width_d = bus.width_16;
          cnt_d   = 5'd0;
          tx_d    = hold_q;
        end
      end
      ST_SHIFT: begin
        if (cs_lvl) begin
          state_d = ST_IDLE;
        end else if (sclk_rise) begin
          rx_d  = {rx_q[14:0], mosi_lvl};
          cnt_d = cnt_inc;
          if (cnt_inc == word_bits(width_q)) state_d = ST_WORD_DONE;
        end else if (sclk_fall && cnt_q != 5'd0) begin
          // Count 0 means the trailing fall of the previous word: keep the new MSB.
          tx_d = {tx_q[14:0], 1'b0};
        end
      end
      ST_WORD_DONE: begin
        data_rx_d  = width_q ? rx_q : {8'h00, rx_q[7:0]};
        rx_valid_d = 1'b1;
        if (cs_lvl) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SHIFT;
          cnt_d   = 5'd0;
          tx_d    = hold_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rx_full_d = rx_full_q;
    overrun_d = overrun_q;
    if (word_done) rx_full_d = 1'b1;
    else if (bus.rx_ack) rx_full_d = 1'b0;
    if (word_done && rx_full_q && !bus.rx_ack) overrun_d = 1'b1;
    else if (bus.rx_ack) overrun_d = 1'b0;
  end

  always_ff @(posedge raw_clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      width_q    <= 1'b0;
      cnt_q      <= 5'd0;
      tx_q       <= 16'h0;
      rx_q       <= 16'h0;
      hold_q     <= 16'h0;
      data_rx_q  <= 16'h0;
      rx_valid_q <= 1'b0;
      rx_full_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      width_q    <= width_d;
      cnt_q      <= cnt_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      hold_q     <= hold_d;
      data_rx_q  <= data_rx_d;
      rx_valid_q <= rx_valid_d;
      rx_full_q  <= rx_full_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.data_rx  = data_rx_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_full  = rx_full_q;
  assign bus.overrun  = overrun_q;
  assign bus.busy     = (state_q != ST_IDLE);
  assign miso_o = (state_q != ST_IDLE && !cs_lvl) ? (width_q ? tx_q[15] : tx_q[7]) : 1'b0;

endmodule
